// File: rtl/demux_stream_1ton_if.sv
// Stream bundle for the 1-to-N demux: one producer-side stream in, N
// consumer-side valid/ready pairs out over a shared data bus.
interface demux_stream_1ton_if #(
    parameter int N_CH  = 4,
    parameter int DW    = 8,
    parameter int SEL_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [SEL_W-1:0]  in_sel;
    logic              in_bcast;
    logic [N_CH-1:0]   out_valid;
    logic [N_CH-1:0]   out_ready;
    logic [DW-1:0]     out_data;

    // Demux side: consumes the input stream, drives the channel side.
    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data
    );

    // Environment side: producer plus the N consumers.
    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux_stream_1ton.sv
// 1-to-N stream demux with broadcast. A single holding register keeps the
// accepted word plus a per-channel pending mask; each channel drops out of
// the mask as it handshakes, and the next word is taken as soon as the mask
// would be empty. Out-of-range selects are swallowed, pulsed on err_sel and
// counted in a saturating drop counter.
module demux_stream_1ton #(
    parameter int N_CH  = 4,
    parameter int DW    = 8,
    parameter int SEL_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    demux_stream_1ton_if.slave  bus,
    output logic                err_sel,
    output logic [7:0]          drop_cnt
);

    localparam logic [N_CH-1:0] ONE_HOT0 = {{(N_CH-1){1'b0}}, 1'b1};

    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] pend_next;
    logic [DW-1:0]   data_q;
    logic            ready_c;
    logic            accept;
    logic            sel_ok;

    // Pending mask after this cycle's handshakes, and whether a new word fits.
    always_comb begin
        pend_next = pend & ~bus.out_ready;
        ready_c   = (pend_next == '0);
        accept    = bus.in_valid & ready_c;
        sel_ok    = (int'(bus.in_sel) < N_CH);
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = pend;
    assign bus.out_data  = data_q;

    // Holding stage: load a new destination mask and word on accept, else retire handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= '0;
            data_q <= '0;
        end else if (accept) begin
            if (bus.in_bcast) begin
                pend   <= '1;
                data_q <= bus.in_data;
            end else if (sel_ok) begin
                pend   <= ONE_HOT0 << bus.in_sel;
                data_q <= bus.in_data;
            end else begin
                pend   <= '0;
            end
        end else begin
            pend <= pend_next;
        end
    end

    // Drop reporting: one-cycle error pulse per dropped word and a saturating count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel  <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            err_sel <= accept & ~bus.in_bcast & ~sel_ok;
            if (accept && !bus.in_bcast && !sel_ok && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Bench for demux_stream_1ton: a 4-channel and a 3-channel instance run side
// by side against a reference model of the delivery rules, with directed
// steps for routing, hold, broadcast, drops and async reset, then random traffic.
module tb_demux_stream_1ton;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    demux_stream_1ton_if #(.N_CH(4), .DW(8), .SEL_W(2)) bus4 ();
    demux_stream_1ton_if #(.N_CH(3), .DW(8), .SEL_W(2)) bus3 ();

    logic       err4, err3;
    logic [7:0] cnt4, cnt3;

    demux_stream_1ton #(.N_CH(4), .DW(8), .SEL_W(2)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus4),
        .err_sel  (err4),
        .drop_cnt (cnt4)
    );

    demux_stream_1ton #(.N_CH(3), .DW(8), .SEL_W(2)) dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus3),
        .err_sel  (err3),
        .drop_cnt (cnt3)
    );

    int n_asserts = 0;
    int n_fails   = 0;

    // Reference state per instance: channels still owed the word, the word, drop info.
    logic [3:0] m_rem  [2];
    logic [7:0] m_data [2];
    logic       m_err  [2];
    int         m_cnt  [2];

    // Stimulus for the coming cycle, index 0 = 4-channel, 1 = 3-channel.
    logic       s_iv   [2];
    logic [7:0] s_id   [2];
    logic [1:0] s_is   [2];
    logic       s_ib   [2];
    logic [3:0] s_ordy [2];

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_rem[i]  = 4'b0;
            m_data[i] = 8'h00;
            m_err[i]  = 1'b0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic set_idle();
        for (int i = 0; i < 2; i++) begin
            s_iv[i]   = 1'b0;
            s_id[i]   = 8'h00;
            s_is[i]   = 2'd0;
            s_ib[i]   = 1'b0;
            s_ordy[i] = 4'b1111;
        end
    endtask

    // Compare one instance against the model, then advance the model over the coming edge.
    task automatic model_step(input int inst, input int n, input logic [3:0] ov, input logic [7:0] od,
                              input logic ir, input logic es, input logic [7:0] dc);
        logic [3:0] all_ch;
        logic [3:0] still_owed;
        logic       can_take;
        all_ch     = 4'((1 << n) - 1);
        still_owed = m_rem[inst] & ~s_ordy[inst] & all_ch;
        can_take   = (still_owed == 4'b0);
        check_output($sformatf("n%0d_out_valid", n), 32'(ov), 32'(m_rem[inst]));
        check_output($sformatf("n%0d_out_data", n), 32'(od), 32'(m_data[inst]));
        check_output($sformatf("n%0d_in_ready", n), 32'(ir), 32'(can_take));
        check_output($sformatf("n%0d_err_sel", n), 32'(es), 32'(m_err[inst]));
        check_output($sformatf("n%0d_drop_cnt", n), 32'(dc), 32'(m_cnt[inst]));
        if (rst_n) begin
            m_err[inst] = 1'b0;
            if (s_iv[inst] && can_take) begin
                if (s_ib[inst]) begin
                    m_rem[inst]  = all_ch;
                    m_data[inst] = s_id[inst];
                end else if (int'(s_is[inst]) < n) begin
                    m_rem[inst]  = 4'(1 << s_is[inst]);
                    m_data[inst] = s_id[inst];
                end else begin
                    m_rem[inst] = 4'b0;
                    m_err[inst] = 1'b1;
                    if (m_cnt[inst] < 255) m_cnt[inst]++;
                end
            end else begin
                m_rem[inst] = still_owed;
            end
        end
    endtask

    // One cycle: drive inputs on the falling edge, sample shortly after, check both instances.
    task automatic apply_stimulus();
        @(negedge clk);
        bus4.in_valid  = s_iv[0];
        bus4.in_data   = s_id[0];
        bus4.in_sel    = s_is[0];
        bus4.in_bcast  = s_ib[0];
        bus4.out_ready = s_ordy[0];
        bus3.in_valid  = s_iv[1];
        bus3.in_data   = s_id[1];
        bus3.in_sel    = s_is[1];
        bus3.in_bcast  = s_ib[1];
        bus3.out_ready = s_ordy[1][2:0];
        #1;
        model_step(0, 4, bus4.out_valid, bus4.out_data, bus4.in_ready, err4, cnt4);
        model_step(1, 3, {1'b0, bus3.out_valid}, bus3.out_data, bus3.in_ready, err3, cnt3);
    endtask

    initial begin
        $display("[TB] start");
        model_reset();
        set_idle();

        // Reset state
        apply_stimulus();
        check_output("rst_out_valid", 32'(bus4.out_valid), 32'h0);
        check_output("rst_out_data", 32'(bus4.out_data), 32'h0);
        check_output("rst_in_ready", 32'(bus4.in_ready), 32'h1);
        check_output("rst_drop_cnt", 32'(cnt3), 32'h0);
        apply_stimulus();
        rst_n = 1'b1;

        // Route 0xA5 to channels 0..3 back to back with all consumers ready
        for (int i = 0; i <= 4; i++) begin
            s_iv[0] = (i < 4);
            s_id[0] = 8'hA5;
            s_is[0] = 2'(i);
            apply_stimulus();
            check_output("sweep_in_ready", 32'(bus4.in_ready), 32'h1);
            if (i > 0) begin
                check_output("sweep_out_valid", 32'(bus4.out_valid), 32'(1 << (i - 1)));
                check_output("sweep_out_data", 32'(bus4.out_data), 32'hA5);
            end
        end

        // Channel 2 stalls for 5 cycles; next word is taken the cycle it releases
        s_iv[0] = 1'b1; s_id[0] = 8'h3C; s_is[0] = 2'd2; s_ordy[0] = 4'b1011;
        apply_stimulus();
        s_id[0] = 8'h11; s_is[0] = 2'd1;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus();
            check_output("hold_out_valid", 32'(bus4.out_valid), 32'h4);
            check_output("hold_out_data", 32'(bus4.out_data), 32'h3C);
            check_output("hold_in_ready", 32'(bus4.in_ready), 32'h0);
        end
        s_ordy[0] = 4'b1111;
        apply_stimulus();
        check_output("release_in_ready", 32'(bus4.in_ready), 32'h1);

        // Broadcast 0x7E with channels accepting in different cycles
        s_iv[0] = 1'b1; s_id[0] = 8'h7E; s_ib[0] = 1'b1;
        apply_stimulus();
        check_output("next_out_valid", 32'(bus4.out_valid), 32'h2);
        check_output("next_out_data", 32'(bus4.out_data), 32'h11);
        s_iv[0] = 1'b0; s_ib[0] = 1'b0; s_ordy[0] = 4'b0001;
        apply_stimulus();
        check_output("bc_valid_a", 32'(bus4.out_valid), 32'hF);
        check_output("bc_ready_a", 32'(bus4.in_ready), 32'h0);
        s_ordy[0] = 4'b0011;
        apply_stimulus();
        check_output("bc_valid_b", 32'(bus4.out_valid), 32'hE);
        check_output("bc_ready_b", 32'(bus4.in_ready), 32'h0);
        s_ordy[0] = 4'b1111;
        apply_stimulus();
        check_output("bc_valid_c", 32'(bus4.out_valid), 32'hC);
        check_output("bc_ready_c", 32'(bus4.in_ready), 32'h1);
        check_output("bc_data", 32'(bus4.out_data), 32'h7E);
        apply_stimulus();
        check_output("bc_done", 32'(bus4.out_valid), 32'h0);

        // Out-of-range select on the 3-channel instance
        s_iv[1] = 1'b1; s_id[1] = 8'hEE; s_is[1] = 2'd3;
        apply_stimulus();
        s_iv[1] = 1'b0;
        apply_stimulus();
        check_output("drop_err", 32'(err3), 32'h1);
        check_output("drop_cnt1", 32'(cnt3), 32'h1);
        check_output("drop_no_valid", 32'(bus3.out_valid), 32'h0);
        check_output("drop_data_held", 32'(bus3.out_data), 32'h0);
        apply_stimulus();
        check_output("drop_err_clear", 32'(err3), 32'h0);

        // 299 more back-to-back drops saturate the counter
        s_iv[1] = 1'b1;
        for (int i = 0; i < 299; i++) begin
            apply_stimulus();
            if (i == 10) check_output("drop_err_b2b", 32'(err3), 32'h1);
        end
        s_iv[1] = 1'b0;
        apply_stimulus();
        check_output("drop_cnt_sat", 32'(cnt3), 32'hFF);
        apply_stimulus();
        check_output("drop_err_end", 32'(err3), 32'h0);

        // Async reset while channel 2 is holding
        s_iv[0] = 1'b1; s_id[0] = 8'h55; s_is[0] = 2'd2; s_ordy[0] = 4'b0000;
        apply_stimulus();
        s_iv[0] = 1'b0;
        apply_stimulus();
        check_output("pre_rst_valid", 32'(bus4.out_valid), 32'h4);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_valid", 32'(bus4.out_valid), 32'h0);
        check_output("async_rst_data", 32'(bus4.out_data), 32'h0);
        check_output("async_rst_cnt", 32'(cnt3), 32'h0);
        model_reset();
        apply_stimulus();
        rst_n = 1'b1;
        s_iv[0] = 1'b1; s_id[0] = 8'h99; s_is[0] = 2'd1; s_ordy[0] = 4'b1111;
        apply_stimulus();
        s_iv[0] = 1'b0;
        apply_stimulus();
        check_output("post_rst_valid", 32'(bus4.out_valid), 32'h2);
        check_output("post_rst_data", 32'(bus4.out_data), 32'h99);

        // Random traffic on both instances
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                s_iv[i] = ($urandom_range(0, 3) != 0);
                s_id[i] = 8'($urandom);
                s_is[i] = 2'($urandom_range(0, 3));
                s_ib[i] = ($urandom_range(0, 7) == 0);
                for (int b = 0; b < 4; b++) s_ordy[i][b] = ($urandom_range(0, 9) < 7);
            end
            apply_stimulus();
        end
        set_idle();
        apply_stimulus();
        apply_stimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
